// File: rtl/seg_scan_if.sv
// Load/busy handshake plus the segment and digit-select pins of seg_scan_driver.
interface seg_scan_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 14,
    parameter int DPW    = $clog2(DIGITS) + 1
);
    logic              load;
    logic [DATA_W-1:0] value;
    logic [DPW-1:0]    dp_pos;
    logic              busy;
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;

    modport master (output load, value, dp_pos, input busy, seg, sel);
    modport slave  (input load, value, dp_pos, output busy, seg, sel);
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: sequential shift-add-3 binary-to-BCD, then digit scanning.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 20000,
    parameter int DPW      = $clog2(DIGITS) + 1
) (
    input  logic      clk,
    input  logic      rstn,
    seg_scan_if.slave bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  LAST_IT   = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(SCAN_DIV - 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] bin_reg, bin_next;
    logic [BCD_W-1:0]  bcd_reg, bcd_next;
    logic [CNT_W-1:0]  it_reg, it_next;
    logic [DPW-1:0]    dp_reg, dp_next;
    logic              ovf_reg, ovf_next;
    logic [BCD_W-1:0]  disp_bcd_reg, disp_bcd_next;
    logic [DPW-1:0]    disp_dp_reg, disp_dp_next;
    logic              disp_ovf_reg, disp_ovf_next;
    logic [SCAN_W-1:0] scan_reg, scan_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DIGITS-1:0] sel_reg, sel_next;
    logic [7:0]        seg_reg, seg_next;

    logic [BCD_W-1:0]  adj;
    logic [BCD_W-1:0]  bcd_shift;
    logic [DATA_W-1:0] bin_shift;
    logic [3:0]        nibs [DIGITS];
    logic              tick;
    logic [IDX_W-1:0]  idx_adv;
    logic [6:0]        pat;
    logic              dp_hit;
    logic [7:0]        seg_dec;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                              : bcd_reg[4*gi +: 4];
        assign nibs[gi] = disp_bcd_reg[4*gi +: 4];
    end

    // The bin MSB falls into the BCD LSB; the top BCD bit drops off the end.
    assign {bcd_shift, bin_shift} = {adj, bin_reg} << 1;

`ifdef SEG_SCAN_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              blank;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
        assign lz[gi] = (disp_bcd_reg[BCD_W-1:4*gi] == '0);
    end
    assign blank = (idx_adv != '0) && lz[idx_adv] && (DPW'(idx_adv) > disp_dp_reg);
`endif

    assign tick    = (scan_reg == LAST_SCAN);
    assign idx_adv = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);

    // Pattern for the digit about to be selected, taken from the display register as it is now.
    always_comb begin
        case (nibs[idx_adv])
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        dp_hit = (disp_dp_reg != '0) && (DPW'(idx_adv) == disp_dp_reg);
        if (disp_ovf_reg)
            seg_dec = 8'h40;
`ifdef SEG_SCAN_LZB_EN
        else if (blank)
            seg_dec = 8'h00;
`endif
        else
            seg_dec = {dp_hit, pat};
    end

    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        bcd_next      = bcd_reg;
        it_next       = it_reg;
        dp_next       = dp_reg;
        ovf_next      = ovf_reg;
        disp_bcd_next = disp_bcd_reg;
        disp_dp_next  = disp_dp_reg;
        disp_ovf_next = disp_ovf_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.load) begin
                    bin_next   = bus.value;
                    bcd_next   = '0;
                    it_next    = '0;
                    dp_next    = (bus.dp_pos >= DPW'(DIGITS)) ? '0 : bus.dp_pos;
                    ovf_next   = (64'(bus.value) > MAX_VAL);
                    state_next = S_CONV;
                end
            end
            S_CONV: begin
                bin_next = bin_shift;
                bcd_next = bcd_shift;
                it_next  = it_reg + CNT_W'(1);
                if (it_reg == LAST_IT) begin
                    disp_bcd_next = bcd_shift;
                    disp_dp_next  = dp_reg;
                    disp_ovf_next = ovf_reg;
                    state_next    = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        scan_next = tick ? '0 : scan_reg + SCAN_W'(1);
        idx_next  = tick ? idx_adv : idx_reg;
        sel_next  = tick ? (DIGITS'(1) << idx_adv) : sel_reg;
        seg_next  = tick ? seg_dec : seg_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= S_IDLE;
            bin_reg      <= '0;
            bcd_reg      <= '0;
            it_reg       <= '0;
            dp_reg       <= '0;
            ovf_reg      <= 1'b0;
            disp_bcd_reg <= '0;
            disp_dp_reg  <= '0;
            disp_ovf_reg <= 1'b0;
            scan_reg     <= '0;
            idx_reg      <= '0;
            sel_reg      <= DIGITS'(1);
            seg_reg      <= 8'h3F;
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            bcd_reg      <= bcd_next;
            it_reg       <= it_next;
            dp_reg       <= dp_next;
            ovf_reg      <= ovf_next;
            disp_bcd_reg <= disp_bcd_next;
            disp_dp_reg  <= disp_dp_next;
            disp_ovf_reg <= disp_ovf_next;
            scan_reg     <= scan_next;
            idx_reg      <= idx_next;
            sel_reg      <= sel_next;
            seg_reg      <= seg_next;
        end
    end

    assign bus.busy = (state_reg == S_CONV);
    assign bus.seg  = seg_reg;
    assign bus.sel  = sel_reg;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: vector table, corner-case sequences and random loads, all checked
// cycle by cycle against an arithmetic model of the display.
module tb_seg_scan_driver;
    localparam int DIGITS   = 4;
    localparam int DATA_W   = 14;
    localparam int SCAN_DIV = 5;
    localparam int DPW      = $clog2(DIGITS) + 1;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'h3F;
`endif

    logic clk;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if #(.DIGITS(DIGITS), .DATA_W(DATA_W), .DPW(DPW)) bus ();

    seg_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .DPW(DPW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] seg_pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_seg(input int v, input int dp, input int i);
        int p;
        int lim;
        logic [7:0] s;
        p = 1;
        lim = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        for (int k = 0; k < DIGITS; k++) lim = lim * 10;
        if (v >= lim) return 8'h40;
`ifdef SEG_SCAN_LZB_EN
        if (i > 0 && (v / p) == 0 && i > dp) return 8'h00;
`endif
        s = seg_pat[(v / p) % 10];
        if (dp != 0 && i == dp) s[7] = 1'b1;
        return s;
    endfunction

    // Model: edges since reset, pending conversion, shown value and the value latched per slot.
    int cyc, m_left, m_pend_v, m_pend_dp, m_disp_v, m_disp_dp, slot_v, slot_dp;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc <= 0; m_left <= 0; m_pend_v <= 0; m_pend_dp <= 0;
            m_disp_v <= 0; m_disp_dp <= 0; slot_v <= 0; slot_dp <= 0;
        end else begin
            cyc <= cyc + 1;
            if ((cyc + 1) % SCAN_DIV == 0) begin
                slot_v  <= m_disp_v;
                slot_dp <= m_disp_dp;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_disp_v  <= m_pend_v;
                    m_disp_dp <= m_pend_dp;
                end
            end else if (bus.load) begin
                m_left    <= DATA_W;
                m_pend_v  <= int'(bus.value);
                m_pend_dp <= (int'(bus.dp_pos) >= DIGITS) ? 0 : int'(bus.dp_pos);
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("scan_sel", 32'(bus.sel), 32'(1 << ((cyc / SCAN_DIV) % DIGITS)));
            chk("scan_seg", 32'(bus.seg), 32'(model_seg(slot_v, slot_dp, (cyc / SCAN_DIV) % DIGITS)));
            chk("busy", 32'(bus.busy), 32'(m_left != 0));
        end
    end

    // Called at a negedge; returns at the negedge where busy is first seen low again.
    task automatic do_load(input int v, input int dp);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin @(negedge clk); n++; end
        bus.load   = 1'b1;
        bus.value  = DATA_W'(v);
        bus.dp_pos = DPW'(dp);
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin n++; @(negedge clk); end
        chk("busy_cycles", 32'(n), 32'(DATA_W));
    endtask

    task automatic capture(output logic [8*DIGITS-1:0] segs);
        segs = '0;
        repeat (SCAN_DIV) @(negedge clk);
        for (int c = 0; c < (DIGITS + 1) * SCAN_DIV; c++) begin
            for (int i = 0; i < DIGITS; i++)
                if (bus.sel == DIGITS'(1 << i)) segs[8*i +: 8] = bus.seg;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int v;
        int dp;
        logic [8*DIGITS-1:0] exp;
    } vec_t;

    vec_t tbl [9];
    logic [8*DIGITS-1:0] got;

    initial begin
        tbl[0] = '{1234,  0, {8'h06, 8'h5B, 8'h4F, 8'h66}};
        tbl[1] = '{7,     0, {LZ,    LZ,    LZ,    8'h07}};
        tbl[2] = '{5,     3, {8'hBF, 8'h3F, 8'h3F, 8'h6D}};
        tbl[3] = '{10000, 0, {8'h40, 8'h40, 8'h40, 8'h40}};
        tbl[4] = '{9999,  0, {8'h6F, 8'h6F, 8'h6F, 8'h6F}};
        tbl[5] = '{0,     0, {LZ,    LZ,    LZ,    8'h3F}};
        tbl[6] = '{120,   5, {LZ,    8'h06, 8'h5B, 8'h3F}};
        tbl[7] = '{50,    2, {LZ,    8'hBF, 8'h6D, 8'h3F}};
        tbl[8] = '{42,    4, {LZ,    LZ,    8'h66, 8'h5B}};

        rstn = 1'b0;
        bus.load = 1'b0;
        bus.value = '0;
        bus.dp_pos = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_sel", 32'(bus.sel), 32'd1);
        chk("reset_seg", 32'(bus.seg), 32'h3F);
        rstn = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.sel == 4'd1 && n < 100) begin n++; @(negedge clk); end
            chk("reset_hold", 32'(n), 32'(SCAN_DIV));
            chk("after_hold_sel", 32'(bus.sel), 32'd2);
        end

        for (int t = 0; t < 9; t++) begin
            do_load(tbl[t].v, tbl[t].dp);
            capture(got);
            $display("vec %0d value=%0d dp=%0d segs=%h", t, tbl[t].v, tbl[t].dp, got);
            for (int i = 0; i < DIGITS; i++)
                chk($sformatf("vec%0d_digit%0d", t, i), 32'(got[8*i +: 8]), 32'(tbl[t].exp[8*i +: 8]));
        end

        // Second load while busy is dropped.
        bus.load = 1'b1; bus.value = DATA_W'(77); bus.dp_pos = '0;
        @(negedge clk);
        chk("busy_on_accept", 32'(bus.busy), 32'd1);
        bus.value = DATA_W'(99);
        @(negedge clk);
        bus.load = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.busy && n < 100) begin n++; @(negedge clk); end
        end
        capture(got);
        $display("busy-ignore value=77 then 99 segs=%h", got);
        for (int i = 0; i < DIGITS; i++)
            chk($sformatf("ignore_digit%0d", i), 32'(got[8*i +: 8]), 32'(i < 2 ? 8'h07 : LZ));

        // Reset five cycles into a conversion.
        bus.load = 1'b1; bus.value = DATA_W'(1234); bus.dp_pos = '0;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midreset_sel", 32'(bus.sel), 32'd1);
        chk("midreset_seg", 32'(bus.seg), 32'h3F);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        capture(got);
        $display("reset-mid-conversion segs=%h", got);
        for (int i = 0; i < DIGITS; i++)
            chk($sformatf("midreset_digit%0d", i), 32'(got[8*i +: 8]), 32'(i == 0 ? 8'h3F : LZ));

        // Completion landing on a scan tick: that slot keeps the old pattern.
        while ((cyc + 1 + DATA_W) % SCAN_DIV != 0) @(negedge clk);
        do_load(8888, 0);
        chk("coincide_old", 32'(bus.seg), 32'(model_seg(0, 0, (cyc / SCAN_DIV) % DIGITS)));
        capture(got);
        $display("coincide value=8888 segs=%h", got);
        for (int i = 0; i < DIGITS; i++)
            chk($sformatf("coincide_digit%0d", i), 32'(got[8*i +: 8]), 32'h7F);

        for (int r = 0; r < 12; r++) begin
            int v, dp, dpc;
            v = int'($urandom_range(0, 16383));
            dp = int'($urandom_range(0, 7));
            dpc = (dp >= DIGITS) ? 0 : dp;
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_load(v, dp);
            capture(got);
            $display("rand %0d value=%0d dp=%0d segs=%h", r, v, dp, got);
            for (int i = 0; i < DIGITS; i++)
                chk($sformatf("rand%0d_digit%0d", r, i), 32'(got[8*i +: 8]), 32'(model_seg(v, dpc, i)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end
endmodule
